imm_instruction_packer: RTL and testbench
=========================================

# imm_instruction_packer

Generates 16-bit instruction words for the pipeline CPU's instruction set by inserting immediates into templates. It is the encode-side counterpart of the decode-stage immediate extension. It takes a 16-bit constant and either packs it into the immediate field of a single instruction template, or expands it into a short LI/SLL/ADDIU sequence that loads the constant into a register. The block sits between the debug/boot loader and the instruction-memory writer, and streams words out through a valid/ready handshake.

## Interface
Parameters:
- NOP_WORD, 16'h0800, word emitted on encode error and held on out_instr at reset.

Ports:
- clk  input  1  system clock; everything is clocked on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  a request is present.
- req_ready  output  1  the block can accept a request; high only in IDLE.
- req_mode  input  1  0 = pack into template; 1 = load-constant expansion.
- req_im_sel  input  4  immediate format, used in pack mode; bit3 selects sign (1) or zero (0) extension; bits[2:0] select the field.
- req_template  input  16  instruction template, used in pack mode; its immediate-field bits are ignored and overwritten.
- req_reg  input  3  destination register rx, used in load mode.
- req_value  input  16  constant to encode.
- out_valid  output  1  out_instr is valid.
- out_ready  input  1  downstream accepts the word.
- out_instr  output  16  encoded word.
- out_last  output  1  the current word is the final word of its request.
- out_error  output  1  the request could not be encoded; out_instr = NOP_WORD.

## Operation
Request capture:
- A request is accepted when req_valid && req_ready.
- On acceptance, all req_* inputs are registered.

Pack mode: the immediate fits the field and is inserted into out_instr. All non-field bits come from req_template. The formats are:
- 0000: field [7:0]; fits when value < 256.
- 0001: field [3:0]; fits when value < 16.
- 0010: field [4:0]; fits when value < 32.
- 0011: field [10:0]; fits when value < 2048.
- 0100: field [4:2]; fits when value < 8.
- 0101: field [4:2], shift amount; legal values are 1..8; 8 is encoded as 000; value 0 is an error.
- 1000/1001/1010/1011: same fields as 0000/0001/0010/0011; the value fits when bits [15:w-1] are all equal, where w is the field width.
- 1100: field [4:2]; fits when bits [15:2] are all equal.
- 1101, 0110, 0111, 1110, 1111: always an error.

Pack-mode output and errors:
- Pack mode always emits exactly 1 word, with out_last = 1.
- On a value that does not fit or an illegal format: out_instr = NOP_WORD, out_error = 1, out_last = 1.

Load mode arithmetic:
- lo = V[7:0].
- hi_adj = (V[15:8] + V[7]) mod 256.
- Instruction encodings:
  - LI = {5'b01101, rx, imm8}.
  - SLL = {5'b00110, rx, rx, 3'b000, 2'b00}, a shift by 8.
  - ADDIU = {5'b01001, rx, imm8}.

Load mode word selection:
- V[15:8] == 0: 1 word, LI rx, lo.
- Otherwise, if hi_adj == 0: 2 words, LI rx, 0x00 then ADDIU rx, lo.
- Otherwise: 3 words, LI rx, hi_adj; SLL; ADDIU rx, lo.
- Load mode never raises out_error.

FSM states:
- IDLE: req_ready = 1. On acceptance, compute the word count and go to EMIT with word index 0.
- EMIT: out_valid = 1.
  - On out_ready, if the current word is last, go to IDLE.
  - Otherwise, increment the index and present the next word.

## Timing
Reset values:
- The FSM goes to IDLE.
- out_valid = 0, out_instr = NOP_WORD, out_last = 0, out_error = 0.
- req_ready = 1 in the cycle after reset deasserts.

Latency and throughput:
- The first word is valid in the cycle after acceptance, i.e. 1-cycle latency.
- Subsequent words follow in the cycle after each out_ready handshake.
- After the last handshake the block is in IDLE the next cycle, giving 1 bubble between requests.

Handshake rules:
- While out_valid && !out_ready, out_instr, out_last and out_error hold stable.
- out_valid does not drop until the word is accepted.
- req_* inputs are ignored outside IDLE.
- All outputs are registered; req_ready is decoded from state only.

Reset mid-sequence: rst in any state aborts the request in that cycle. The remaining words are dropped and the reset values are applied.

## Test plan
- Pack, zero-extended 8-bit: im_sel 0000, template 0x6900, value 0x00AB -> one word 0x69AB, last=1, err=0.
- Pack, sign-extended 8-bit:
  - im_sel 1000, template 0x4A00, value 0xFF80 -> 0x4A80.
  - Same with value 0x0080 -> 0x0800, err=1.
- Pack, shift-amount field: im_sel 0101, template 0x3120:
  - value 8 -> 0x3120.
  - value 3 -> 0x312C.
  - value 0 -> 0x0800, err=1.
  - im_sel 1101 -> err=1.
- Load mode, rx=3:
  - value 0x12F0 -> 0x6B13, 0x3360, 0x4BF0, with last on the third word only.
  - value 0x007F -> single 0x6B7F.
  - value 0xFF80 -> 0x6B00, 0x4B80.
- Backpressure: value 0x12F0 with out_ready held low for 3 cycles while word 2 is presented -> 0x3360 stable with out_valid=1 throughout; no word is skipped or duplicated.
- Reset during word 2 of a 3-word sequence -> next cycle out_valid=0, out_instr=0x0800, req_ready=1; a following request encodes correctly.

Source files
------------

// File: rtl/imm_instruction_packer_if.sv
// rtl/imm_instruction_packer_if.sv - request/output handshake bundle for the immediate packer
interface imm_instruction_packer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [3:0]  req_im_sel;
    logic [15:0] req_template;
    logic [2:0]  req_reg;
    logic [15:0] req_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_last;
    logic        out_error;

    modport master (
        output req_valid, req_mode, req_im_sel, req_template, req_reg, req_value, out_ready,
        input  req_ready, out_valid, out_instr, out_last, out_error
    );

    modport slave (
        input  req_valid, req_mode, req_im_sel, req_template, req_reg, req_value, out_ready,
        output req_ready, out_valid, out_instr, out_last, out_error
    );
endinterface

// File: rtl/imm_instruction_packer.sv
// rtl/imm_instruction_packer.sv - packs immediates into templates or expands LI/SLL/ADDIU load sequences
module imm_instruction_packer #(
    parameter logic [15:0] NOP_WORD = 16'h0800
) (
    input  logic                      clk,
    input  logic                      rst,
    imm_instruction_packer_if.slave   bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  nwords;
    logic [15:0] word1, word2;
    logic        out_valid_r, out_last_r, out_error_r;
    logic [15:0] out_instr_r;

    logic [15:0] v, t;
    logic [7:0]  hi_adj;
    logic [2:0]  rx;
    logic        fit;
    logic [15:0] pk;
    logic [15:0] enc_w0, enc_w1, enc_w2;
    logic [1:0]  enc_n;
    logic        enc_err;

    assign v      = bus.req_value;
    assign t      = bus.req_template;
    assign rx     = bus.req_reg;
    assign hi_adj = v[15:8] + {7'd0, v[7]};

    always_comb begin
        fit = 1'b0;
        pk  = NOP_WORD;
        case (bus.req_im_sel)
            4'b0000: begin fit = (v < 16'd256);  pk = {t[15:8], v[7:0]};  end
            4'b0001: begin fit = (v < 16'd16);   pk = {t[15:4], v[3:0]};  end
            4'b0010: begin fit = (v < 16'd32);   pk = {t[15:5], v[4:0]};  end
            4'b0011: begin fit = (v < 16'd2048); pk = {t[15:11], v[10:0]}; end
            4'b0100: begin fit = (v < 16'd8);    pk = {t[15:5], v[2:0], t[1:0]}; end
            // Shift amount 1..8; 8 wraps to 000 by truncation.
            4'b0101: begin fit = (v >= 16'd1) && (v <= 16'd8); pk = {t[15:5], v[2:0], t[1:0]}; end
            4'b1000: begin fit = (&v[15:7])  || ~(|v[15:7]);  pk = {t[15:8], v[7:0]};  end
            4'b1001: begin fit = (&v[15:3])  || ~(|v[15:3]);  pk = {t[15:4], v[3:0]};  end
            4'b1010: begin fit = (&v[15:4])  || ~(|v[15:4]);  pk = {t[15:5], v[4:0]};  end
            4'b1011: begin fit = (&v[15:10]) || ~(|v[15:10]); pk = {t[15:11], v[10:0]}; end
            4'b1100: begin fit = (&v[15:2])  || ~(|v[15:2]);  pk = {t[15:5], v[2:0], t[1:0]}; end
            default: begin fit = 1'b0; pk = NOP_WORD; end
        endcase
    end

    always_comb begin
        enc_w0  = NOP_WORD;
        enc_w1  = NOP_WORD;
        enc_w2  = NOP_WORD;
        enc_n   = 2'd1;
        enc_err = 1'b0;
        if (bus.req_mode) begin
            if (v[15:8] == 8'd0) begin
                enc_w0 = {5'b01101, rx, v[7:0]};
            end else if (hi_adj == 8'd0) begin
                enc_n  = 2'd2;
                enc_w0 = {5'b01101, rx, 8'h00};
                enc_w1 = {5'b01001, rx, v[7:0]};
            end else begin
                enc_n  = 2'd3;
                enc_w0 = {5'b01101, rx, hi_adj};
                enc_w1 = {5'b00110, rx, rx, 3'b000, 2'b00};
                enc_w2 = {5'b01001, rx, v[7:0]};
            end
        end else if (fit) begin
            enc_w0 = pk;
        end else begin
            enc_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            nwords      <= 2'd1;
            word1       <= NOP_WORD;
            word2       <= NOP_WORD;
            out_valid_r <= 1'b0;
            out_instr_r <= NOP_WORD;
            out_last_r  <= 1'b0;
            out_error_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        word1       <= enc_w1;
                        word2       <= enc_w2;
                        nwords      <= enc_n;
                        idx         <= 2'd0;
                        out_valid_r <= 1'b1;
                        out_instr_r <= enc_w0;
                        out_last_r  <= (enc_n == 2'd1);
                        out_error_r <= enc_err;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_r) begin
                            state       <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_error_r <= 1'b0;
                        end else begin
                            idx         <= idx + 2'd1;
                            out_instr_r <= (idx == 2'd0) ? word1 : word2;
                            out_last_r  <= ((idx + 2'd2) == nwords);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_error = out_error_r;
endmodule

// File: tb/tb_imm_instruction_packer.sv
// tb/tb_imm_instruction_packer.sv - scoreboard bench for imm_instruction_packer
module tb_imm_instruction_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_instruction_packer_if bus ();

    imm_instruction_packer #(.NOP_WORD(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] instr;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void push(input logic [15:0] instr, input logic last, input logic err);
        exp_t e;
        e.instr = instr;
        e.last  = last;
        e.err   = err;
        sb.push_back(e);
    endfunction

    // Integer reference for the load expansion.
    function automatic void push_load(input int rx, input int value);
        int lo, h, ha;
        lo = value % 256;
        h  = (value / 256) % 256;
        ha = (h + lo / 128) % 256;
        if (h == 0) begin
            push(16'(32'h6800 + rx * 256 + lo), 1'b1, 1'b0);
        end else if (ha == 0) begin
            push(16'(32'h6800 + rx * 256), 1'b0, 1'b0);
            push(16'(32'h4800 + rx * 256 + lo), 1'b1, 1'b0);
        end else begin
            push(16'(32'h6800 + rx * 256 + ha), 1'b0, 1'b0);
            push(16'(32'h3000 + rx * 256 + rx * 32), 1'b0, 1'b0);
            push(16'(32'h4800 + rx * 256 + lo), 1'b1, 1'b0);
        end
    endfunction

    task automatic send_req(input logic mode, input logic [3:0] sel, input logic [15:0] tmpl,
                            input logic [2:0] rx, input logic [15:0] value);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            $display("FAIL req_ready_timeout: req_ready=%0b required 1", bus.req_ready);
        end
        bus.req_valid    = 1'b1;
        bus.req_mode     = mode;
        bus.req_im_sel   = sel;
        bus.req_template = tmpl;
        bus.req_reg      = rx;
        bus.req_value    = value;
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
    endtask

    task automatic get_word(output logic [15:0] instr, output logic last, output logic err, output bit ok);
        int n = 0;
        ok    = 1'b0;
        instr = 16'hxxxx;
        last  = 1'bx;
        err   = 1'bx;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.out_valid) begin
            ok    = 1'b1;
            instr = bus.out_instr;
            last  = bus.out_last;
            err   = bus.out_error;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.out_valid, bus.out_instr, bus.out_last, bus.out_error, bus.req_ready} !== {1'b0, 16'h0800, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: valid=%0b instr=%h last=%0b err=%0b ready=%0b required 0 0800 0 0 1",
                     bus.out_valid, bus.out_instr, bus.out_last, bus.out_error, bus.req_ready);
        else passed++;
    endtask

    task automatic test_pack();
        logic [15:0] i; logic l, e; bit ok; exp_t ex;
        logic [3:0]  sel [13];
        logic [15:0] tm  [13];
        logic [15:0] val [13];
        sel = '{4'b0000, 4'b1000, 4'b1000, 4'b0101, 4'b0101, 4'b0101, 4'b1101,
                4'b0001, 4'b0001, 4'b0011, 4'b1010, 4'b1100, 4'b0110};
        tm  = '{16'h6900, 16'h4A00, 16'h4A00, 16'h3120, 16'h3120, 16'h3120, 16'h3120,
                16'hFFFF, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h1234};
        val = '{16'h00AB, 16'hFF80, 16'h0080, 16'h0008, 16'h0003, 16'h0000, 16'h0003,
                16'h000A, 16'h0010, 16'h07FF, 16'hFFF0, 16'hFFFD, 16'h0001};
        push(16'h69AB, 1, 0); push(16'h4A80, 1, 0); push(16'h0800, 1, 1);
        push(16'h3120, 1, 0); push(16'h312C, 1, 0); push(16'h0800, 1, 1);
        push(16'h0800, 1, 1); push(16'hFFFA, 1, 0); push(16'h0800, 1, 1);
        push(16'h17FF, 1, 0); push(16'h0010, 1, 0); push(16'h0014, 1, 0);
        push(16'h0800, 1, 1);
        for (int k = 0; k < 13; k++) begin
            send_req(1'b0, sel[k], tm[k], 3'd0, val[k]);
            get_word(i, l, e, ok);
            ex = sb.pop_front();
            total++;
            if (!ok) $display("FAIL pack_%0d: no output word, required %h", k, ex.instr);
            else if ({i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL pack_%0d: got %h last=%0b err=%0b required %h last=%0b err=%0b",
                         k, i, l, e, ex.instr, ex.last, ex.err);
            else passed++;
        end
    endtask

    task automatic test_load();
        logic [15:0] i; logic l, e; bit ok; exp_t ex;
        push(16'h6B13, 0, 0); push(16'h3360, 0, 0); push(16'h4BF0, 1, 0);
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'h12F0);
        while (sb.size() > 0) begin
            get_word(i, l, e, ok); ex = sb.pop_front(); total++;
            if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL load_12f0: got %h last=%0b err=%0b required %h last=%0b err=%0b",
                         i, l, e, ex.instr, ex.last, ex.err);
            else passed++;
        end
        push(16'h6B7F, 1, 0);
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'h007F);
        while (sb.size() > 0) begin
            get_word(i, l, e, ok); ex = sb.pop_front(); total++;
            if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL load_007f: got %h last=%0b err=%0b required %h", i, l, e, ex.instr);
            else passed++;
        end
        push(16'h6B00, 0, 0); push(16'h4B80, 1, 0);
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'hFF80);
        while (sb.size() > 0) begin
            get_word(i, l, e, ok); ex = sb.pop_front(); total++;
            if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL load_ff80: got %h last=%0b err=%0b required %h last=%0b", i, l, e, ex.instr, ex.last);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] i; logic l, e; bit ok; exp_t ex;
        push_load(3, 16'h12F0);
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'h12F0);
        get_word(i, l, e, ok); ex = sb.pop_front(); total++;
        if (!ok || i !== ex.instr) $display("FAIL bp_word1: got %h required %h", i, ex.instr);
        else passed++;
        // Stall word 2 while a stray request is offered; it must be ignored.
        bus.req_valid = 1'b1;
        bus.req_mode  = 1'b0;
        bus.req_value = 16'h0001;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({bus.out_valid, bus.out_instr, bus.out_last} !== {1'b1, sb[0].instr, sb[0].last})
                $display("FAIL bp_hold_%0d: valid=%0b instr=%h last=%0b required 1 %h %0b",
                         c, bus.out_valid, bus.out_instr, bus.out_last, sb[0].instr, sb[0].last);
            else passed++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        while (sb.size() > 0) begin
            get_word(i, l, e, ok); ex = sb.pop_front(); total++;
            if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL bp_tail: got %h last=%0b required %h last=%0b", i, l, ex.instr, ex.last);
            else passed++;
        end
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_no_extra: out_valid=%0b required 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] i; logic l, e; bit ok; exp_t ex;
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'h12F0);
        get_word(i, l, e, ok);
        total++;
        if (bus.out_instr !== 16'h3360) $display("FAIL rst_mid_word2: got %h required 3360", bus.out_instr);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_instr, bus.out_last, bus.req_ready} !== {1'b0, 16'h0800, 1'b0, 1'b1})
            $display("FAIL rst_mid_state: valid=%0b instr=%h last=%0b ready=%0b required 0 0800 0 1",
                     bus.out_valid, bus.out_instr, bus.out_last, bus.req_ready);
        else passed++;
        sb.delete();
        push_load(3, 16'h12F0);
        send_req(1'b1, 4'd0, 16'h0, 3'd3, 16'h12F0);
        while (sb.size() > 0) begin
            get_word(i, l, e, ok); ex = sb.pop_front(); total++;
            if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                $display("FAIL rst_mid_after: got %h last=%0b required %h last=%0b", i, l, ex.instr, ex.last);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] i; logic l, e; bit ok; exp_t ex;
        logic [15:0] v;
        logic [2:0]  r;
        for (int k = 0; k < 12; k++) begin
            v = 16'($urandom);
            if (k % 4 == 0) v[15:8] = 8'h00;
            if (k % 4 == 1) v = {8'hFF, 1'b1, v[6:0]};
            r = 3'($urandom_range(0, 7));
            push_load(int'(r), int'(v));
            send_req(1'b1, 4'd0, 16'h0, r, v);
            while (sb.size() > 0) begin
                get_word(i, l, e, ok); ex = sb.pop_front(); total++;
                if (!ok || {i, l, e} !== {ex.instr, ex.last, ex.err})
                    $display("FAIL b2b_%0d v=%h rx=%0d: got %h last=%0b err=%0b required %h last=%0b",
                             k, v, r, i, l, e, ex.instr, ex.last);
                else passed++;
            end
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_mode     = 1'b0;
        bus.req_im_sel   = 4'd0;
        bus.req_template = 16'h0;
        bus.req_reg      = 3'd0;
        bus.req_value    = 16'h0;
        bus.out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_pack();
        test_load();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
